bitmap_fetch: RTL and testbench

- Upstream feeder for the note/length match accelerator.
- On a `go` request it reads a 1536-bit glyph bitmap from memory as 48 consecutive 32-bit words and assembles them into the `bmr` bus.
- It then pulses `start` to the accelerator and holds `bmr` stable until the accelerator's `finish` returns.
- It reports completion with `done`, or a memory timeout with `err`.

---
 rtl/match_pkg.sv | 21 ++
 rtl/fetch_timeout.sv | 27 ++
 rtl/bitmap_fetch.sv | 113 +++++++++++
 tb/tb_bitmap_fetch.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared definitions for the bitmap fetcher and the note/length match accelerator.
// The state encoding is also used by the accelerator bench.
package match_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 48;
    localparam int BMR_W     = WORD_W * NUM_WORDS;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        START,
        MWAIT
    } fetch_state_t;

    function automatic logic is_busy(input fetch_state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/fetch_timeout.sv
// 8-bit saturating wait counter with synchronous clear and count enable.
// expired flags the enabled cycle whose increment brings the count up to LIMIT.
module fetch_timeout #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    assign expired = en && (count == LIMIT - 8'd1);

endmodule

// File: rtl/bitmap_fetch.sv
// Reads a glyph bitmap word by word into bmr, kicks the match accelerator and
// holds bmr stable until the accelerator reports finish.
module bitmap_fetch #(
    parameter int ADDR_W    = 16,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 48,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          go,
    input  logic [ADDR_W-1:0]             base_addr,
    output logic                          mem_rd,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [WORD_W-1:0]             mem_rdata,
    input  logic                          mem_valid,
    output logic [NUM_WORDS*WORD_W-1:0]   bmr,
    output logic                          start,
    input  logic                          match_finish,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    import match_pkg::*;

    localparam int               CNT_W     = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

    fetch_state_t      state;
    logic [CNT_W-1:0]  wordCnt;
    logic [ADDR_W-1:0] baseAddr;
    logic              tmoClr;
    logic              tmoEn;
    logic              tmoExpired;

    // The wait budget counts from the strobe cycle, so err lands TIMEOUT
    // cycles after the mem_rd of the word that never came back.
    assign tmoClr = (state == IDLE && go) || (state == WAIT && mem_valid && !err);
    assign tmoEn  = (state == REQ) || (state == WAIT && !mem_valid && !err);

    fetch_timeout #(
        .LIMIT(8'(TIMEOUT))
    ) uTimeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmoClr),
        .en     (tmoEn),
        .expired(tmoExpired)
    );

    assign busy = is_busy(state);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            bmr      <= '0;
            wordCnt  <= '0;
            baseAddr <= '0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            start    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            start  <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        baseAddr <= base_addr;
                        wordCnt  <= '0;
                        mem_rd   <= 1'b1;
                        mem_addr <= base_addr;
                        state    <= REQ;
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    // err is held for its pulse cycle in WAIT so a late go cannot slip in.
                    if (err) begin
                        state <= IDLE;
                    end else if (mem_valid) begin
                        bmr[int'(wordCnt)*WORD_W +: WORD_W] <= mem_rdata;
                        if (wordCnt == LAST_WORD) begin
                            start <= 1'b1;
                            state <= START;
                        end else begin
                            wordCnt  <= wordCnt + CNT_W'(1);
                            mem_rd   <= 1'b1;
                            mem_addr <= baseAddr + ADDR_W'(wordCnt) + ADDR_W'(1);
                            state    <= REQ;
                        end
                    end else if (tmoExpired) begin
                        err <= 1'b1;
                    end
                end
                START: state <= MWAIT;
                MWAIT: begin
                    // done pulses while still in MWAIT, keeping busy high that cycle.
                    if (done) begin
                        state <= IDLE;
                    end else if (match_finish) begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitmap_fetch.sv
// Randomized scoreboard bench for bitmap_fetch: a memory model answers reads,
// a monitor checks every strobe and start/done/err against queued expectations.
module tb_bitmap_fetch;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          go = 1'b0;
    logic [15:0]   base_addr = '0;
    logic          mem_rd;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic          mem_valid = 1'b0;
    logic [1535:0] bmr;
    logic          start;
    logic          match_finish = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    bitmap_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .base_addr   (base_addr),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .bmr         (bmr),
        .start       (start),
        .match_finish(match_finish),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int EV_START = 0, EV_DONE = 1, EV_ERR = 2;
    typedef struct {
        int            kind;
        logic [1535:0] bmr;
    } evt_t;

    int            checks = 0, failures = 0;
    logic [31:0]   memArr [0:65535];
    logic [1535:0] modelBmr = '0;
    logic [15:0]   expAddr[$];
    evt_t          evq[$];
    int            nStart = 0, nDone = 0, nErr = 0;
    int            expStart = 0, expDone = 0, expErr = 0;
    int            latMin = 1, latMax = 1;
    bit            spurEn = 0, dropEn = 0;
    logic [15:0]   dropAddr = '0;
    int            respCd = -1;
    logic [15:0]   respAddr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chkBmr(input string name, input logic [1535:0] act, input logic [1535:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int w = 0; w < 48; w++) begin
                if (act[w*32 +: 32] !== exp[w*32 +: 32]) begin
                    $display("FAIL %s: word %0d got %08h expected %08h (cycle %0d)",
                             name, w, act[w*32 +: 32], exp[w*32 +: 32], cyc);
                    break;
                end
            end
        end
    endtask

    function automatic logic sigVal(input int sel);
        case (sel)
            0:       return start === 1'b1;
            1:       return done === 1'b1;
            2:       return err === 1'b1;
            default: return mem_rd === 1'b1;
        endcase
    endfunction

    // Memory model: answers each strobe after latMin..latMax cycles.
    initial begin
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            mem_rdata = $urandom;
            if (respCd == 0) begin
                mem_valid = 1'b1;
                mem_rdata = memArr[respAddr];
                respCd = -1;
            end else if (respCd > 0) begin
                respCd--;
            end
            if (mem_rd === 1'b1) begin
                if (!(dropEn && mem_addr == dropAddr)) begin
                    respAddr = mem_addr;
                    respCd = int'($urandom_range(latMax, latMin)) - 1;
                end
                if (spurEn && !mem_valid && $urandom_range(1, 0) == 1) mem_valid = 1'b1;
            end else if (spurEn && busy === 1'b0 && !mem_valid && $urandom_range(1, 0) == 1) begin
                mem_valid = 1'b1;
            end
        end
    end

    task automatic evCheck(input int kind, input string name);
        evt_t e;
        if (evq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
        end else begin
            e = evq.pop_front();
            chk({name, "_kind"}, kind, e.kind);
            chkBmr({name, "_bmr"}, bmr, e.bmr);
        end
    endtask

    // Monitor: compares every DUT output event with the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_rd === 1'b1) begin
                if (expAddr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_mem_rd: addr %04h (cycle %0d)", mem_addr, cyc);
                end else begin
                    chk("mem_addr", mem_addr, expAddr.pop_front());
                end
            end
            if (start === 1'b1) begin nStart++; evCheck(EV_START, "start"); end
            if (done === 1'b1)  begin nDone++;  evCheck(EV_DONE, "done");   end
            if (err === 1'b1)   begin nErr++;   evCheck(EV_ERR, "err");     end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            go = 1'b0;
            match_finish = 1'b0;
        end
    endtask

    task automatic waitSig(input int sel, input int nth, input int bound, input string name,
                           output int at);
        int seen = 0;
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            go = 1'b0;
            match_finish = 1'b0;
            if (sigVal(sel)) begin
                seen++;
                if (seen == nth) begin
                    at = cyc;
                    break;
                end
            end
        end
        if (at < 0) begin
            checks++;
            failures++;
            $display("FAIL %s: no event within %0d cycles", name, bound);
        end
    endtask

    task automatic fillMem(input logic [15:0] b, input bit pat);
        for (int k = 0; k < 48; k++)
            memArr[16'(b + k)] = pat ? (32'hA500_0000 | 32'(k)) : $urandom;
    endtask

    // Reference: word k comes from address (base + k) mod 2^16 into bmr slot k.
    task automatic expectFetch(input logic [15:0] b, input int nReq, input int nWr, input int kind);
        for (int k = 0; k < nReq; k++) expAddr.push_back(16'(b + k));
        for (int k = 0; k < nWr; k++) modelBmr[k*32 +: 32] = memArr[16'(b + k)];
        if (kind == EV_START) begin
            evq.push_back('{EV_START, modelBmr});
            evq.push_back('{EV_DONE, modelBmr});
            expStart++;
            expDone++;
        end else if (kind == EV_ERR) begin
            evq.push_back('{EV_ERR, modelBmr});
            expErr++;
        end
    endtask

    task automatic issueGo(input logic [15:0] b, output int g);
        @(negedge clk);
        match_finish = 1'b0;
        go = 1'b1;
        base_addr = b;
        g = cyc;
    endtask

    task automatic finishAfter(input int hold, input bit chkHold, input bit goInDone);
        int f, d;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            go = 1'b0;
            if (chkHold) chk("mwait_busy_bmr_stable", {busy, bmr === modelBmr}, 2'b11);
        end
        match_finish = 1'b1;
        f = cyc;
        waitSig(1, 1, 20, "done_wait", d);
        chk("done_latency", d - f, 1);
        chk("busy_in_done_cycle", busy, 1);
        if (goInDone) begin
            go = 1'b1;
            base_addr = 16'h5555;
        end
        step(1);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        int g, s, r, e, nd;
        logic [15:0] b;
        step(3);
        chk("reset_busy", busy, 0);
        chk("reset_mem_rd", mem_rd, 0);
        chk("reset_start_done_err", {start, done, err}, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chkBmr("reset_bmr", bmr, '0);
        rst = 1'b1;
        step(2);

        // Nominal fetch, 1-cycle memory.
        fillMem(16'h0100, 1);
        expectFetch(16'h0100, 48, 48, EV_START);
        issueGo(16'h0100, g);
        waitSig(0, 1, 2000, "start_nominal", s);
        chk("start_latency", s - g, 97);
        chk("bmr_word0", bmr[31:0], 32'hA500_0000);
        chk("bmr_word47", bmr[1535:1504], 32'hA500_002F);
        finishAfter(20, 1, 0);

        // Variable latency with stray mem_valid in REQ and IDLE.
        latMin = 1; latMax = 10; spurEn = 1;
        repeat (2) begin
            b = 16'($urandom);
            fillMem(b, 0);
            expectFetch(b, 48, 48, EV_START);
            issueGo(b, g);
            waitSig(0, 1, 2000, "start_varlat", s);
            finishAfter(int'($urandom_range(5, 1)), 1, 0);
        end
        step(10);
        chkBmr("idle_stray_valid_bmr", bmr, modelBmr);
        spurEn = 0; latMin = 1; latMax = 1;

        // Timeout on word 5: words 0-4 land, the rest keep the previous bitmap.
        b = 16'($urandom);
        fillMem(b, 0);
        dropEn = 1;
        dropAddr = 16'(b + 5);
        expectFetch(b, 6, 5, EV_ERR);
        issueGo(b, g);
        waitSig(3, 6, 100, "word5_rd", r);
        waitSig(2, 1, 400, "err_wait", e);
        chk("err_latency", e - r, 255);
        step(1);
        chk("idle_after_err", busy, 0);
        chk("no_start_on_err", nStart, expStart);
        dropEn = 0;

        // Reset during word 20, then a clean restart at the same base.
        b = 16'($urandom);
        fillMem(b, 0);
        expectFetch(b, 48, 0, -1);
        issueGo(b, g);
        waitSig(3, 21, 200, "word20_rd", r);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        chk("midreset_busy", busy, 0);
        chk("midreset_mem_rd", mem_rd, 0);
        chkBmr("midreset_bmr", bmr, '0);
        expAddr.delete();
        modelBmr = '0;
        step(12);
        expectFetch(b, 48, 48, EV_START);
        issueGo(b, g);
        waitSig(0, 1, 2000, "start_restart", s);
        chk("restart_latency", s - g, 97);
        finishAfter(3, 0, 0);

        // go in WAIT, finish in START, go in MWAIT and in the done cycle: all ignored.
        latMin = 3; latMax = 3;
        b = 16'($urandom);
        fillMem(b, 0);
        expectFetch(b, 48, 48, EV_START);
        issueGo(b, g);
        waitSig(3, 3, 100, "word2_rd", r);
        step(1);
        go = 1'b1;
        base_addr = ~b;
        waitSig(0, 1, 2000, "start_ignored_go", s);
        match_finish = 1'b1;
        nd = nDone;
        step(3);
        go = 1'b1;
        base_addr = ~b;
        step(3);
        chk("no_done_from_start_cycle_finish", nDone, nd);
        chk("single_start", nStart, expStart);
        finishAfter(1, 1, 1);
        step(5);
        chk("stay_idle_after_done_go", busy, 0);
        latMin = 1; latMax = 1;

        // Address wrap across 0xFFFF.
        fillMem(16'hFFF0, 0);
        expectFetch(16'hFFF0, 48, 48, EV_START);
        issueGo(16'hFFF0, g);
        waitSig(0, 1, 2000, "start_wrap", s);
        chk("wrap_latency", s - g, 97);
        finishAfter(2, 0, 0);
        step(3);

        chk("addr_queue_drained", expAddr.size(), 0);
        chk("event_queue_drained", evq.size(), 0);
        chk("start_count", nStart, expStart);
        chk("done_count", nDone, expDone);
        chk("err_count", nErr, expErr);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
